detector_sequencer: RTL



---
 rtl/detector_sequencer_if.sv | 26 ++
 rtl/detector_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/detector_sequencer_if.sv
// Bundle between the switch/button front end, the run controller and the
// detector instance. The sequencer is the slave: it takes run requests and
// the detector response, and drives the detector input plus run results.
interface detector_sequencer_if;
  logic        start;
  logic        abort;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic        z_in;
  logic        w;
  logic        fsm_reset;
  logic        busy;
  logic        done;
  logic [4:0]  hits;
  logic [15:0] hit_mask;

  modport master (
    output start, abort, pattern, length, z_in,
    input  w, fsm_reset, busy, done, hits, hit_mask
  );

  modport slave (
    input  start, abort, pattern, length, z_in,
    output w, fsm_reset, busy, done, hits, hit_mask
  );
endinterface

// File: rtl/detector_sequencer.sv
// Run controller for the 3-bit sequence detector: resets the detector, feeds
// a latched pattern LSB first on w, records z one cycle after each bit and
// reports a per-bit hit mask, a hit count and a one-cycle done pulse.
module detector_sequencer (
  input  logic                 clk,
  input  logic                 reset,
  detector_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pattern_q, pattern_d;
  logic [4:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] hit_mask_q, hit_mask_d;
  logic [4:0]  hits_q, hits_d;

  logic        busy_s;
  logic        accept_start;
  logic        abort_run;
  logic        last_bit;
  logic        sample_en;
  logic        clear_results;
  logic [3:0]  sample_idx;
  logic [4:0]  len_clamped;

  // Lengths above the pattern width run the full pattern.
  assign len_clamped   = (bus.length > 5'd16) ? 5'd16 : bus.length;
  assign busy_s        = (state_q == ST_CLEAR) || (state_q == ST_SHIFT) ||
                         (state_q == ST_DRAIN);
  assign accept_start  = (state_q == ST_IDLE) && bus.start;
  assign abort_run     = busy_s && bus.abort;
  assign last_bit      = ({1'b0, idx_q} == (len_q - 5'd1));
  assign clear_results = accept_start || abort_run;

  // z lags w by one cycle, so SHIFT with idx records bit idx-1 and DRAIN
  // records the final bit. idx is left at len-1 on entry to DRAIN, so it
  // already names that final bit.
  assign sample_en  = !abort_run &&
                      (((state_q == ST_SHIFT) && (idx_q != 4'd0)) ||
                       (state_q == ST_DRAIN));
  assign sample_idx = (state_q == ST_DRAIN) ? idx_q : (idx_q - 4'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; abort from any busy state wins over normal flow.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (len_clamped == 5'd0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (last_bit) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_run) begin
      state_d = ST_IDLE;
    end
  end

  // Output decode; fsm_reset also covers the controller's own reset and abort.
  always_comb begin
    bus.w         = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = busy_s;
    bus.fsm_reset = reset || abort_run;
    bus.hits      = hits_q;
    bus.hit_mask  = hit_mask_q;
    case (state_q)
      ST_CLEAR: bus.fsm_reset = 1'b1;
      ST_SHIFT: bus.w = pattern_q[idx_q];
      ST_DONE:  bus.done = 1'b1;
      default:  ;
    endcase
  end

  // Run parameters, bit index and hit counter.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    idx_d     = idx_q;
    hits_d    = hits_q;
    if (accept_start) begin
      pattern_d = bus.pattern;
      len_d     = len_clamped;
    end
    if (state_q == ST_CLEAR) begin
      idx_d = 4'd0;
    end else if ((state_q == ST_SHIFT) && !last_bit) begin
      idx_d = idx_q + 4'd1;
    end
    if (clear_results) begin
      hits_d = 5'd0;
    end else if (sample_en && bus.z_in) begin
      hits_d = hits_q + 5'd1;
    end
  end

  // Per-bit hit mask update: each bit only listens when it is being sampled.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_hit
      assign hit_mask_d[gi] = clear_results ? 1'b0 :
                              (sample_en && (sample_idx == 4'(gi))) ? bus.z_in :
                              hit_mask_q[gi];
    end
  endgenerate

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q  <= 16'd0;
      len_q      <= 5'd0;
      idx_q      <= 4'd0;
      hit_mask_q <= 16'd0;
      hits_q     <= 5'd0;
    end else begin
      pattern_q  <= pattern_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      hit_mask_q <= hit_mask_d;
      hits_q     <= hits_d;
    end
  end

endmodule
